// File: rtl/nvdla_cfgrom_csb_master.sv
// CSB master for the config-ROM slave: single outstanding host request, packed
// into a CSB packet, issued, then the response (or a timeout error) returned.
module nvdla_cfgrom_csb_master #(
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter logic        SRCPRIV        = 1'b1,
  parameter logic [1:0]  LEVEL          = 2'd0
) (
  input  logic        nvdla_core_clk,
  input  logic        nvdla_core_rst,
  input  logic        host_req_valid,
  output logic        host_req_ready,
  input  logic [21:0] host_req_addr,
  input  logic [31:0] host_req_wdat,
  input  logic        host_req_write,
  input  logic        host_req_nposted,
  input  logic [3:0]  host_req_wrbe,
  output logic [62:0] csb2cfgrom_req_pd,
  output logic        csb2cfgrom_req_pvld,
  input  logic        csb2cfgrom_req_prdy,
  input  logic [33:0] cfgrom2csb_resp_pd,
  input  logic        cfgrom2csb_resp_valid,
  output logic        host_resp_valid,
  input  logic        host_resp_ready,
  output logic [31:0] host_resp_rdat,
  output logic        host_resp_error,
  output logic        host_resp_is_write,
  output logic        stray_resp
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  localparam int unsigned   CW       = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [1:0]    state_q, state_d;
  logic [62:0]   pd_q, pd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   rdat_q, rdat_d;
  logic          error_q, error_d;
  logic          is_write_q, is_write_d;
  logic          stray_q, stray_d;

  logic req_is_write;
  logic req_posted;
  assign req_is_write = pd_q[54];
  assign req_posted   = pd_q[54] & ~pd_q[55];

  always_comb begin
    state_d    = state_q;
    pd_d       = pd_q;
    cnt_d      = cnt_q;
    rdat_d     = rdat_q;
    error_d    = error_q;
    is_write_d = is_write_q;
    // Any response outside WAIT is unexpected (including late ones after a timeout).
    stray_d    = cfgrom2csb_resp_valid & (state_q != WAIT);
    case (state_q)
      IDLE: begin
        if (host_req_valid) begin
          pd_d = {LEVEL,
                  host_req_write ? host_req_wrbe : 4'hF,
                  SRCPRIV,
                  host_req_nposted & host_req_write,
                  host_req_write,
                  host_req_wdat,
                  host_req_addr};
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (csb2cfgrom_req_prdy) begin
          if (req_posted) begin
            state_d = IDLE;
          end else begin
            state_d = WAIT;
            cnt_d   = '0;
          end
        end
      end
      WAIT: begin
        // A response arriving on the expiry cycle takes priority over the timeout.
        if (cfgrom2csb_resp_valid) begin
          state_d = RESP;
          if (cfgrom2csb_resp_pd[33] != req_is_write) begin
            rdat_d     = '0;
            error_d    = 1'b1;
            is_write_d = req_is_write;
            stray_d    = 1'b1;
          end else begin
            rdat_d     = cfgrom2csb_resp_pd[31:0];
            error_d    = cfgrom2csb_resp_pd[32];
            is_write_d = cfgrom2csb_resp_pd[33];
          end
        end else if (cnt_q == CNT_LAST) begin
          state_d    = RESP;
          rdat_d     = '0;
          error_d    = 1'b1;
          is_write_d = req_is_write;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        if (host_resp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      state_q    <= IDLE;
      pd_q       <= '0;
      cnt_q      <= '0;
      rdat_q     <= '0;
      error_q    <= 1'b0;
      is_write_q <= 1'b0;
      stray_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pd_q       <= pd_d;
      cnt_q      <= cnt_d;
      rdat_q     <= rdat_d;
      error_q    <= error_d;
      is_write_q <= is_write_d;
      stray_q    <= stray_d;
    end
  end

  assign host_req_ready      = (state_q == IDLE) & ~nvdla_core_rst;
  assign csb2cfgrom_req_pd   = pd_q;
  assign csb2cfgrom_req_pvld = (state_q == ISSUE);
  assign host_resp_valid     = (state_q == RESP);
  assign host_resp_rdat      = rdat_q;
  assign host_resp_error     = error_q;
  assign host_resp_is_write  = is_write_q;
  assign stray_resp          = stray_q;

endmodule
